spin_lattice_sweeper: RTL
=========================

Name: spin_lattice_sweeper

Overview:
- Sequencer that drives a single Ising spin-update cell across an internal W×H spin lattice.
- It is the initiator side of the spin-cell interface: it presents centre spin, four periodic-boundary neighbours, enable and a 32-bit random word, then writes the cell's result back into the lattice.
- Uses a checkerboard sweep order (even parity sites first, then odd) and tracks net magnetization.
- Host side: start/sweep-count handshake and a registered lattice read port.

Parameters:
- W, 16, lattice width; power of 2, ≥4.
- H, 16, lattice height; power of 2, ≥4.
- CELL_LAT, 2, cycles cell inputs are held stable before cell_result is sampled; ≥1.
- AW, log2(W*H), site address width; derived, do not override.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin run; sampled only in IDLE.
- sweeps, input, 16, number of full lattice sweeps; sampled with start.
- busy, output, 1, run in progress.
- done, output, 1, one-cycle pulse at end of run.
- rand_in, input, 32, random word from external generator.
- rand_req, output, 1, one-cycle pulse; rand_in is consumed on this cycle.
- cell_spin, output, 1, centre spin to the cell.
- cell_left, output, 1, neighbour (x-1 mod W, y).
- cell_right, output, 1, neighbour (x+1 mod W, y).
- cell_top, output, 1, neighbour (x, y-1 mod H).
- cell_bottom, output, 1, neighbour (x, y+1 mod H).
- cell_rand32, output, 32, latched random word for the cell.
- cell_enable, output, 1, high while a site is being presented.
- cell_result, input, 1, new spin from the cell.
- rd_addr, input, AW, read address = y*W+x.
- rd_spin, output, 1, lattice[rd_addr]; 1-cycle registered latency.
- mag, output, AW+2 signed, Σ(spin?+1:−1) over the lattice.

Behaviour:
- Spin encoding: 1 = up, 0 = down.
- Reset (asynchronous): entire lattice = 1; mag = W*H; busy=0; done=0; rand_req=0; cell_enable=0; all cell_* outputs 0; rd_spin=0; FSM=IDLE; sweep counter=0. Reset mid-run aborts immediately with no partial state retained.
- FSM states: IDLE, PRESENT, WRITE, DONE.
- IDLE:
  - start=1 and sweeps≠0 → load sweep counter, site pointer = (0,0), phase=0, busy=1 next cycle, go to PRESENT.
  - start=1 and sweeps=0 → go to DONE.
- PRESENT:
  - Lasts exactly CELL_LAT cycles.
  - First cycle: rand_req=1, and cell_rand32 ← rand_in (registered).
  - Throughout: cell_enable=1; centre and neighbours are driven from registers and are stable for the whole state.
  - Neighbour indices wrap: x=0 left→W-1; x=W-1 right→0; y=0 top→H-1; y=H-1 bottom→0.
- WRITE (1 cycle):
  - lattice[site] ← cell_result; cell_enable=0.
  - If the spin changed: mag += 2 when 0→1, mag −= 2 when 1→0.
  - Advance to the next site with (x+y)%2 == phase, raster order (x fastest, then y).
  - After the last site of phase 0 → phase 1, starting at (1,0).
  - After the last site of phase 1 → decrement sweeps; nonzero → phase 0 at (0,0); zero → DONE.
- Cycle timing:
  - Per site: CELL_LAT+1 cycles.
  - Per sweep: W*H*(CELL_LAT+1) cycles.
- DONE (1 cycle): done=1, busy=0; next state IDLE.
- start asserted while busy is ignored.
- rd_addr reads are allowed at any time and return the lattice value after the last completed WRITE edge. A read of the site being written in the same cycle returns the old value.

Optional Feature:
- SWEEPER_MAG_EN
- Defined: mag is tracked as described above.
- Undefined: mag tracking logic is removed and the mag port is driven constant 0; all other behaviour is unchanged.

Test Plan:
- Reset check (W=H=4, CELL_LAT=2): assert rst_n=0 → busy=0, done=0, mag=16; after release, rd_spin=1 for every rd_addr 0..15.
- Single sweep, cell_result tied to 0: start with sweeps=1 at edge N → busy=1 from N+1; done pulses exactly at N+1+48; afterwards all 16 sites read 0 and mag=−16.
- Sweep order and wrap (same run):
  - Phase 0 addresses are presented in order 0,2,5,7,8,10,13,15; all four neighbours read 1.
  - Phase 1 starts at address 1 with left, right, top and bottom all 0.
  - At site (0,0): cell_left comes from address 3 and cell_top from address 12.
- Random handshake: rand_in=0xDEADBEEF → rand_req pulses once per site (16 pulses per sweep); cell_rand32=0xDEADBEEF from the second PRESENT cycle onward.
- Edge starts: start with sweeps=0 → done on the next cycle, busy stays 0, lattice and mag unchanged. A second start pulse mid-run is ignored, so done occurs only once.
- Reset mid-run: drop rst_n during sweep 2 of 3 → outputs reset immediately, lattice all 1, mag=16. With SWEEPER_MAG_EN undefined, mag=0 throughout.

Source files
------------

// File: rtl/spin_lattice_sweeper.sv
// spin_lattice_sweeper: drives one Ising spin-update cell across an internal
// W x H periodic lattice in checkerboard order (even sites, then odd sites).
// Optional feature macro: SWEEPER_MAG_EN. When it is defined, mag tracks the
// net magnetization. When it is undefined, mag is tied to zero.
module spin_lattice_sweeper #(
  parameter int W        = 16,
  parameter int H        = 16,
  parameter int CELL_LAT = 2,
  localparam int AW      = $clog2(W*H)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [15:0]          sweeps,
  output logic                 busy,
  output logic                 done,
  input  logic [31:0]          rand_in,
  output logic                 rand_req,
  output logic                 cell_spin,
  output logic                 cell_left,
  output logic                 cell_right,
  output logic                 cell_top,
  output logic                 cell_bottom,
  output logic [31:0]          cell_rand32,
  output logic                 cell_enable,
  input  logic                 cell_result,
  input  logic [AW-1:0]        rd_addr,
  output logic                 rd_spin,
  output logic signed [AW+1:0] mag
);

  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int CW = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PRESENT = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  // Site address is {y, x} because W is a power of two (addr = y*W + x).
  function automatic logic spin_at(input logic [W*H-1:0] lat,
                                   input logic [YW-1:0]  yy,
                                   input logic [XW-1:0]  xx);
    spin_at = lat[{yy, xx}];
  endfunction

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            phase_q, phase_d;
  logic [15:0]     sweeps_q, sweeps_d;
  logic [CW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [W*H-1:0]  lattice_q, lattice_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rand_req_q, rand_req_d;
  logic            cell_enable_q, cell_enable_d;
  logic            cell_spin_q, cell_spin_d;
  logic            cell_left_q, cell_left_d;
  logic            cell_right_q, cell_right_d;
  logic            cell_top_q, cell_top_d;
  logic            cell_bottom_q, cell_bottom_d;
  logic [31:0]     cell_rand32_q, cell_rand32_d;
  logic            rd_spin_q, rd_spin_d;
  logic            enter_present_s;
  logic [AW-1:0]   site_s;

  assign site_s = {y_q, x_q};

  // Next-state, site sequencing and cell-interface values
  always_comb begin
    state_d         = state_q;
    x_d             = x_q;
    y_d             = y_q;
    phase_d         = phase_q;
    sweeps_d        = sweeps_q;
    lat_cnt_d       = lat_cnt_q;
    lattice_d       = lattice_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    rand_req_d      = 1'b0;
    cell_enable_d   = cell_enable_q;
    cell_spin_d     = cell_spin_q;
    cell_left_d     = cell_left_q;
    cell_right_d    = cell_right_q;
    cell_top_d      = cell_top_q;
    cell_bottom_d   = cell_bottom_q;
    cell_rand32_d   = cell_rand32_q;
    rd_spin_d       = lattice_q[rd_addr];
    enter_present_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (sweeps != 16'd0) begin
            sweeps_d        = sweeps;
            x_d             = '0;
            y_d             = '0;
            phase_d         = 1'b0;
            busy_d          = 1'b1;
            enter_present_s = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (rand_req_q) begin
          cell_rand32_d = rand_in;
        end else begin
          cell_rand32_d = cell_rand32_q;
        end
        if (lat_cnt_q == CW'(CELL_LAT - 1)) begin
          state_d       = WRITE;
          cell_enable_d = 1'b0;
        end else begin
          lat_cnt_d = lat_cnt_q + CW'(1);
        end
      end
      WRITE: begin
        lattice_d[site_s] = cell_result;
        // Raster walk restricted to sites of the current parity: step x by 2,
        // and at row end move to the first matching x of the next row.
        if (x_q[XW-1:1] != (XW-1)'(W/2 - 1)) begin
          x_d             = x_q + XW'(2);
          enter_present_s = 1'b1;
        end else if (y_q != YW'(H - 1)) begin
          y_d             = y_q + YW'(1);
          x_d             = {{(XW-1){1'b0}}, (~y_q[0]) ^ phase_q};
          enter_present_s = 1'b1;
        end else if (phase_q == 1'b0) begin
          phase_d         = 1'b1;
          x_d             = XW'(1);
          y_d             = '0;
          enter_present_s = 1'b1;
        end else begin
          sweeps_d = sweeps_q - 16'd1;
          if (sweeps_q != 16'd1) begin
            phase_d         = 1'b0;
            x_d             = '0;
            y_d             = '0;
            enter_present_s = 1'b1;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Neighbours come from the post-write lattice so a fresh result is never missed.
    if (enter_present_s) begin
      state_d       = PRESENT;
      lat_cnt_d     = '0;
      rand_req_d    = 1'b1;
      cell_enable_d = 1'b1;
      cell_spin_d   = spin_at(lattice_d, y_d, x_d);
      cell_left_d   = spin_at(lattice_d, y_d, x_d - XW'(1));
      cell_right_d  = spin_at(lattice_d, y_d, x_d + XW'(1));
      cell_top_d    = spin_at(lattice_d, y_d - YW'(1), x_d);
      cell_bottom_d = spin_at(lattice_d, y_d + YW'(1), x_d);
    end else begin
      lat_cnt_d = lat_cnt_d;
    end
  end

  // Registers for FSM, lattice, read port and all outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      phase_q       <= 1'b0;
      sweeps_q      <= 16'd0;
      lat_cnt_q     <= '0;
      lattice_q     <= '1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rand_req_q    <= 1'b0;
      cell_enable_q <= 1'b0;
      cell_spin_q   <= 1'b0;
      cell_left_q   <= 1'b0;
      cell_right_q  <= 1'b0;
      cell_top_q    <= 1'b0;
      cell_bottom_q <= 1'b0;
      cell_rand32_q <= 32'd0;
      rd_spin_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      phase_q       <= phase_d;
      sweeps_q      <= sweeps_d;
      lat_cnt_q     <= lat_cnt_d;
      lattice_q     <= lattice_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rand_req_q    <= rand_req_d;
      cell_enable_q <= cell_enable_d;
      cell_spin_q   <= cell_spin_d;
      cell_left_q   <= cell_left_d;
      cell_right_q  <= cell_right_d;
      cell_top_q    <= cell_top_d;
      cell_bottom_q <= cell_bottom_d;
      cell_rand32_q <= cell_rand32_d;
      rd_spin_q     <= rd_spin_d;
    end
  end

`ifdef SWEEPER_MAG_EN
  logic signed [AW+1:0] mag_q, mag_d;

  // Magnetization moves by +/-2 only when the written spin actually flips
  always_comb begin
    mag_d = mag_q;
    if ((state_q == WRITE) && (cell_result != lattice_q[site_s])) begin
      if (cell_result) begin
        mag_d = mag_q + (AW+2)'(2);
      end else begin
        mag_d = mag_q - (AW+2)'(2);
      end
    end else begin
      mag_d = mag_q;
    end
  end

  // Magnetization register; the reset lattice is all up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q <= (AW+2)'(W*H);
    end else begin
      mag_q <= mag_d;
    end
  end

  assign mag = mag_q;
`else
  assign mag = '0;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign rand_req    = rand_req_q;
  assign cell_enable = cell_enable_q;
  assign cell_spin   = cell_spin_q;
  assign cell_left   = cell_left_q;
  assign cell_right  = cell_right_q;
  assign cell_top    = cell_top_q;
  assign cell_bottom = cell_bottom_q;
  assign cell_rand32 = cell_rand32_q;
  assign rd_spin     = rd_spin_q;

endmodule
